// File: rtl/fb_vport_pkg.sv
// Shared types and helpers for the frame-buffer video port:
// alignment state, RGB555 field layout, colour expansion and raster totals.
package fb_vport_pkg;

   typedef enum logic {
      SEEK = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned C_W   = 5;
   localparam int unsigned R_LSB = 10;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_LSB = 0;

   // Replicating the top bits keeps full-scale 0x1F mapped to 0xFF.
   function automatic logic [7:0] expand5to8(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   function automatic int unsigned h_tot(input int unsigned act, input int unsigned fp,
                                         input int unsigned sw, input int unsigned bp);
      return act + fp + sw + bp;
   endfunction

   function automatic int unsigned v_tot(input int unsigned act, input int unsigned fp,
                                         input int unsigned sw, input int unsigned bp);
      return act + fp + sw + bp;
   endfunction

endpackage

// File: rtl/fb_vport_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; writes into a full FIFO
// are dropped, reads from an empty FIFO are ignored.
module fb_vport_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               iWR,
   input  logic [WIDTH-1:0]   iDATA,
   input  logic               iRD,
   output logic [WIDTH-1:0]   oDATA,
   output logic [$clog2(DEPTH):0] oCOUNT,
   output logic               oEMPTY
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;

   assign w_full = (r_count == CW'(DEPTH));
   assign oEMPTY = (r_count == '0);
   assign w_wr   = iWR && !w_full;
   assign w_rd   = iRD && !oEMPTY;
   assign oDATA  = r_mem[r_rptr];
   assign oCOUNT = r_count;

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end

   always_ff @(posedge iCLK) begin
      if (w_wr) r_mem[r_wptr] <= iDATA;
   end

endmodule

// File: rtl/fb_vport_timing.sv
// DVI raster timing generator that pulls RGB555 pixels from a frame-buffer
// stream, expands them to RGB888 and keeps frame alignment via the start flag.
module fb_vport_timing
   import fb_vport_pkg::*;
#(
   parameter int unsigned H_ACT      = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SW       = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACT      = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SW       = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        iCLK,
   input  logic        iRESET,
   input  logic        iFB_START,
   input  logic [14:0] iFB_DATA,
   input  logic        iFB_DV,
   output logic        oFB_READY,
   output logic [7:0]  oRED,
   output logic [7:0]  oGRN,
   output logic [7:0]  oBLU,
   output logic        oHS,
   output logic        oVS,
   output logic        oDE,
   output logic        oFRAME,
   output logic        oUNDERFLOW,
   output logic        oRESYNC
);

   localparam int unsigned H_TOT = h_tot(H_ACT, H_FP, H_SW, H_BP);
   localparam int unsigned V_TOT = v_tot(V_ACT, V_FP, V_SW, V_BP);
   localparam int unsigned HW    = $clog2(H_TOT);
   localparam int unsigned VW    = $clog2(V_TOT);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   state_t        r_state;
   state_t        w_state_n;

   logic [15:0]   w_head;
   logic [CW-1:0] w_count;
   logic          w_empty;
   logic          w_pop;
   logic          w_show;
   logic          w_frame;
   logic          w_under;
   logic          w_resync;
   logic          w_active;
   logic          w_org;
   logic          w_sof;
   logic          w_hs_on;
   logic          w_vs_on;

   logic [7:0]    r_red, r_grn, r_blu;
   logic          r_hs, r_vs, r_de, r_frame, r_under, r_resync, r_ready;

   fb_vport_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .iWR    (iFB_DV),
      .iDATA  ({iFB_START, iFB_DATA}),
      .iRD    (w_pop),
      .oDATA  (w_head),
      .oCOUNT (w_count),
      .oEMPTY (w_empty)
   );

   assign w_active = (r_hcnt < HW'(H_ACT)) && (r_vcnt < VW'(V_ACT));
   assign w_org    = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_sof    = w_head[15];
   assign w_hs_on  = (r_hcnt >= HW'(H_ACT + H_FP)) && (r_hcnt < HW'(H_ACT + H_FP + H_SW));
   assign w_vs_on  = (r_vcnt >= VW'(V_ACT + V_FP)) && (r_vcnt < VW'(V_ACT + V_FP + V_SW));

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (r_hcnt == HW'(H_TOT - 1)) begin
         r_hcnt <= '0;
         r_vcnt <= (r_vcnt == VW'(V_TOT - 1)) ? '0 : r_vcnt + VW'(1);
      end else begin
         r_hcnt <= r_hcnt + HW'(1);
      end
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) r_state <= SEEK;
      else        r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      w_pop     = 1'b0;
      w_show    = 1'b0;
      w_frame   = 1'b0;
      w_under   = 1'b0;
      w_resync  = 1'b0;
      case (r_state)
         SEEK: begin
            if (!w_empty) begin
               if (!w_sof) begin
                  w_pop = 1'b1;
               end else if (w_org) begin
                  w_state_n = RUN;
                  w_pop     = 1'b1;
                  w_show    = 1'b1;
                  w_frame   = 1'b1;
               end
            end
         end
         RUN: begin
            if (w_active) begin
               if (w_empty) begin
                  w_under   = 1'b1;
                  w_resync  = 1'b1;
                  w_state_n = SEEK;
               // Start flag must coincide exactly with the origin; either
               // mismatch direction means the stream has slipped.
               end else if (w_sof != w_org) begin
                  w_resync  = 1'b1;
                  w_state_n = SEEK;
               end else begin
                  w_pop   = 1'b1;
                  w_show  = 1'b1;
                  w_frame = w_org;
               end
            end
         end
         default: w_state_n = SEEK;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_red    <= '0;
         r_grn    <= '0;
         r_blu    <= '0;
         r_hs     <= ~HS_POL;
         r_vs     <= ~VS_POL;
         r_de     <= 1'b0;
         r_frame  <= 1'b0;
         r_under  <= 1'b0;
         r_resync <= 1'b0;
         r_ready  <= 1'b0;
      end else begin
         r_red    <= w_show ? expand5to8(w_head[R_LSB +: C_W]) : '0;
         r_grn    <= w_show ? expand5to8(w_head[G_LSB +: C_W]) : '0;
         r_blu    <= w_show ? expand5to8(w_head[B_LSB +: C_W]) : '0;
         r_hs     <= w_hs_on ? HS_POL : ~HS_POL;
         r_vs     <= w_vs_on ? VS_POL : ~VS_POL;
         r_de     <= w_active;
         r_frame  <= w_frame;
         r_under  <= w_under;
         r_resync <= w_resync;
         // Judged on the pre-edge count so a beat already in flight still fits.
         r_ready  <= (w_count <= CW'(FIFO_DEPTH - 2));
      end
   end

   assign oRED       = r_red;
   assign oGRN       = r_grn;
   assign oBLU       = r_blu;
   assign oHS        = r_hs;
   assign oVS        = r_vs;
   assign oDE        = r_de;
   assign oFRAME     = r_frame;
   assign oUNDERFLOW = r_under;
   assign oRESYNC    = r_resync;
   assign oFB_READY  = r_ready;

endmodule

// File: tb/tb_fb_vport_timing.sv
// Randomised bench for fb_vport_timing on a reduced raster, checked every cycle
// against a queue-based behavioural model of the port.
module tb_fb_vport_timing;

   localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 2;
   localparam int unsigned VA = 4, VF = 1, VSW = 2, VB = 1;
   localparam int unsigned HT = HA + HF + HSW + HB;
   localparam int unsigned VT = VA + VF + VSW + VB;
   localparam int unsigned DEPTH = 4;
   localparam bit HPOL = 1'b1;
   localparam bit VPOL = 1'b0;
   localparam int unsigned NPIX = HA * VA;
   localparam int unsigned NCYC = 7000;
   localparam int unsigned TRUNC_F = 18;

   logic        iCLK = 1'b0;
   logic        iRESET;
   logic        iFB_START;
   logic [14:0] iFB_DATA;
   logic        iFB_DV;
   logic        oFB_READY;
   logic [7:0]  oRED, oGRN, oBLU;
   logic        oHS, oVS, oDE, oFRAME, oUNDERFLOW, oRESYNC;

   fb_vport_timing #(
      .H_ACT(HA), .H_FP(HF), .H_SW(HSW), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SW(VSW), .V_BP(VB),
      .HS_POL(HPOL), .VS_POL(VPOL), .FIFO_DEPTH(DEPTH)
   ) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iFB_START(iFB_START), .iFB_DATA(iFB_DATA),
      .iFB_DV(iFB_DV), .oFB_READY(oFB_READY), .oRED(oRED), .oGRN(oGRN), .oBLU(oBLU),
      .oHS(oHS), .oVS(oVS), .oDE(oDE), .oFRAME(oFRAME), .oUNDERFLOW(oUNDERFLOW),
      .oRESYNC(oRESYNC)
   );

   always #5 iCLK = ~iCLK;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Behavioural model: FIFO as a queue, raster position from elapsed cycles.
   logic [15:0] q[$];
   bit          locked;
   int unsigned t;
   bit          e_ready;
   logic [23:0] e_rgb;
   bit          e_de, e_hs, e_vs, e_frame, e_under, e_resync;

   function automatic logic [7:0] x58(input int unsigned c);
      return 8'(((c << 3) | (c >> 2)) & 255);
   endfunction

   function automatic logic [23:0] rgb_of(input logic [15:0] e);
      int unsigned w;
      w = int'(e[14:0]);
      return {x58((w / 1024) % 32), x58((w / 32) % 32), x58(w % 32)};
   endfunction

   task automatic model_reset();
      q.delete();
      locked = 0;
      t = 0;
      e_ready = 0;
   endtask

   task automatic model_step(input bit dv, input bit st, input logic [14:0] d);
      int unsigned h, v, pre;
      bit act, org, pop;
      h = t % HT;
      v = t / HT;
      act = (h < HA) && (v < VA);
      org = (h == 0) && (v == 0);
      pre = q.size();
      pop = 0;
      e_rgb = '0; e_frame = 0; e_under = 0; e_resync = 0;
      e_de = act;
      e_hs = (h >= HA + HF && h < HA + HF + HSW) ? HPOL : !HPOL;
      e_vs = (v >= VA + VF && v < VA + VF + VSW) ? VPOL : !VPOL;
      if (!locked) begin
         if (pre > 0) begin
            if (!q[0][15]) pop = 1;
            else if (org) begin
               locked = 1; pop = 1; e_rgb = rgb_of(q[0]); e_frame = 1;
            end
         end
      end else if (act) begin
         if (pre == 0) begin
            e_under = 1; e_resync = 1; locked = 0;
         end else if (q[0][15] && !org) begin
            e_resync = 1; locked = 0;
         end else if (!q[0][15] && org) begin
            e_resync = 1; locked = 0;
         end else begin
            pop = 1; e_rgb = rgb_of(q[0]); e_frame = org;
         end
      end
      if (pop) void'(q.pop_front());
      if (dv && pre < DEPTH) q.push_back({st, d});
      e_ready = (DEPTH - pre) >= 2;
      t = (t + 1) % (HT * VT);
   endtask

   // Producer: frames of NPIX pixels; frame 0 lacks its start flag and frame
   // TRUNC_F is cut after two pixels so the next frame starts early.
   int unsigned pp, pf, flen;
   bit          nostart;

   task automatic prod_next_frame();
      pp = 0;
      pf++;
      flen = (pf == TRUNC_F) ? 2 : NPIX;
      nostart = 0;
   endtask

   function automatic logic [14:0] pix(input int unsigned idx);
      case (idx)
         0: return 15'h7C00;
         1: return 15'h03E0;
         2: return 15'h001F;
         3: return 15'h7FFF;
         default: return 15'($urandom);
      endcase
   endfunction

   initial begin
      bit want;
      iRESET = 1'b1; iFB_DV = 1'b0; iFB_START = 1'b0; iFB_DATA = '0;
      pp = 0; pf = 0; flen = NPIX; nostart = 1;
      model_reset();
      for (cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc < 3 || (cyc >= 3000 && cyc < 3003)) begin
            iRESET = 1'b1; iFB_DV = 1'b0; iFB_START = 1'b0;
            model_reset();
            if (cyc >= 3000) begin
               pp = 0; pf++; flen = NPIX; nostart = 0;
            end
            #1;
            check("rst_rgb", 32'({oRED, oGRN, oBLU}), 32'd0);
            check("rst_de", 32'(oDE), 32'd0);
            check("rst_hs", 32'(oHS), 32'(!HPOL));
            check("rst_vs", 32'(oVS), 32'(!VPOL));
            check("rst_ready", 32'(oFB_READY), 32'd0);
            check("rst_pulses", 32'({oFRAME, oUNDERFLOW, oRESYNC}), 32'd0);
            @(posedge iCLK);
            #1;
         end else begin
            iRESET = 1'b0;
            if (cyc >= 1455 && cyc < 1470)      want = 0;
            else if (cyc >= 3003 && cyc < 5000) want = e_ready && ($urandom_range(0, 7) != 0);
            else if (cyc >= 5000 && cyc < 5600) want = ($urandom_range(0, 1) != 0);
            else                                want = e_ready;
            iFB_DV = want;
            iFB_START = want && (pp == 0) && !nostart;
            iFB_DATA = want ? pix(pp) : 15'($urandom);
            if (want) begin
               pp++;
               if (pp >= flen) prod_next_frame();
            end
            @(posedge iCLK);
            model_step(iFB_DV, iFB_START, iFB_DATA);
            #1;
            check("rgb", 32'({oRED, oGRN, oBLU}), 32'(e_rgb));
            check("de", 32'(oDE), 32'(e_de));
            check("hs", 32'(oHS), 32'(e_hs));
            check("vs", 32'(oVS), 32'(e_vs));
            check("frame", 32'(oFRAME), 32'(e_frame));
            check("underflow", 32'(oUNDERFLOW), 32'(e_under));
            check("resync", 32'(oRESYNC), 32'(e_resync));
            check("ready", 32'(oFB_READY), 32'(e_ready));
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
